// File: rtl/serv_decode_q_if.sv
`default_nettype none
// ============================================================================
// Module   : serv_decode_q_if
// Purpose  : Fetch-side and decode-side signals of the queued SERV decoder.
// Revision : 1.0
// ============================================================================
interface serv_decode_q_if #(
  parameter int DEPTH = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      i_wb_rdt;
  logic             i_wb_en;
  logic             o_ibuf_full;
  logic [CNT_W-1:0] o_ibuf_count;
  logic             i_flush;
  logic             i_dec_ready;
  logic             o_dec_valid;
  logic [4:0]       o_rd_addr;
  logic [4:0]       o_rs1_addr;
  logic [4:0]       o_rs2_addr;
  logic             o_mem_op;
  logic             o_branch_op;
  logic             o_shift_op;
  logic             o_slt_op;
  logic             o_rd_op;
  logic             o_alu_sub;
  logic             o_csr_op;
  logic             o_e_op;
  logic             o_ebreak;
  logic [2:0]       o_funct3;
  logic [3:0]       o_alu_rd_sel;
  logic [3:0]       o_immdec_ctrl;
  logic [24:0]      o_imm_raw;
  logic             o_illegal;

  modport master (
    output i_wb_rdt, i_wb_en, i_flush, i_dec_ready,
    input  o_ibuf_full, o_ibuf_count, o_dec_valid,
    input  o_rd_addr, o_rs1_addr, o_rs2_addr,
    input  o_mem_op, o_branch_op, o_shift_op, o_slt_op, o_rd_op,
    input  o_alu_sub, o_csr_op, o_e_op, o_ebreak,
    input  o_funct3, o_alu_rd_sel, o_immdec_ctrl, o_imm_raw, o_illegal
  );

  modport slave (
    input  i_wb_rdt, i_wb_en, i_flush, i_dec_ready,
    output o_ibuf_full, o_ibuf_count, o_dec_valid,
    output o_rd_addr, o_rs1_addr, o_rs2_addr,
    output o_mem_op, o_branch_op, o_shift_op, o_slt_op, o_rd_op,
    output o_alu_sub, o_csr_op, o_e_op, o_ebreak,
    output o_funct3, o_alu_rd_sel, o_immdec_ctrl, o_imm_raw, o_illegal
  );
endinterface
`default_nettype wire

// File: rtl/serv_decode_q.sv
`default_nettype none
// ============================================================================
// Module   : serv_decode_q
// Purpose  : DEPTH-entry instruction buffer feeding a registered SERV decoder.
//            Define SERV_DECODE_ILLEGAL_EN to build the illegal-insn checker.
// Revision : 1.0
// ============================================================================
module serv_decode_q #(
  parameter int DEPTH = 2
) (
  input  wire logic      clk,
  input  wire logic      i_rst_n,
  serv_decode_q_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_FENCE  = 5'b00011;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  logic [31:0]      r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_dec_valid;
  logic [4:0]       r_rd_addr, r_rs1_addr, r_rs2_addr;
  logic             r_mem_op, r_branch_op, r_shift_op, r_slt_op, r_rd_op;
  logic             r_alu_sub, r_csr_op, r_e_op, r_ebreak;
  logic [2:0]       r_funct3;
  logic [3:0]       r_alu_rd_sel;
  logic [3:0]       r_immdec_ctrl;
  logic [24:0]      r_imm_raw;

  logic             w_has_data, w_load, w_bypass, w_pop, w_push;
  logic [PTR_W-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [31:0]      w_insn;
  logic [4:0]       w_op;
  logic [2:0]       w_f3;
  logic             w_is_sys, w_is_alu;
  logic             w_mem_op, w_branch_op, w_shift_op, w_slt_op, w_rd_op;
  logic             w_alu_sub, w_csr_op, w_e_op;
  logic [3:0]       w_alu_rd_sel, w_immdec_ctrl;

  // An empty buffer lets a fetched word go straight into the decode stage.
  assign w_has_data = (r_count != '0);
  assign w_load     = (!r_dec_valid || bus.i_dec_ready) && (w_has_data || bus.i_wb_en);
  assign w_bypass   = !w_has_data && bus.i_wb_en && w_load;
  assign w_pop      = w_load && w_has_data;
  assign w_push     = bus.i_wb_en && !w_bypass && ((r_count != CNT_FULL) || w_pop);

  assign w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);

  assign w_insn = w_bypass ? bus.i_wb_rdt : r_mem[r_rd_ptr];
  assign w_op   = w_insn[6:2];
  assign w_f3   = w_insn[14:12];

  assign w_is_sys    = (w_op == OPC_SYSTEM);
  assign w_is_alu    = (w_op == OPC_OP) || (w_op == OPC_OPIMM);
  assign w_mem_op    = !w_op[4] && !w_op[2] && !w_op[0];
  assign w_branch_op = w_op[4] && !w_op[2];
  assign w_rd_op     = (w_op == OPC_OPIMM) || (w_op == OPC_AUIPC) || (w_op == OPC_OP) ||
                       (w_op == OPC_LUI) || (w_op == OPC_SYSTEM) || (w_op == OPC_JAL) ||
                       (w_op == OPC_JALR) || (w_op == OPC_LOAD);
  assign w_shift_op  = w_is_alu && (w_f3[1:0] == 2'b01);
  assign w_slt_op    = w_is_alu && (w_f3[2:1] == 2'b01);
  assign w_alu_sub   = w_f3[1] || w_f3[0] || (w_op[3] && w_insn[30]) || w_op[4];
  assign w_csr_op    = w_is_sys && (w_f3 != 3'b000);
  assign w_e_op      = w_is_sys && (w_f3 == 3'b000) && (w_insn[31:21] == 11'd0) &&
                       (w_insn[19:7] == 13'd0) && !w_insn[21];

  assign w_alu_rd_sel = {w_f3[2] && (w_f3[1:0] != 2'b01),
                         w_f3[2:1] == 2'b01,
                         w_f3[1:0] == 2'b01,
                         w_f3 == 3'b000};
  assign w_immdec_ctrl = {w_op[4],
                          w_op[4] && !w_op[0],
                          (w_op[1:0] == 2'b00) || (w_op[2:1] == 2'b00),
                          w_op[3:0] == 4'b1000};

  always_ff @(posedge clk) begin
    if (w_push && !bus.i_flush) begin
      r_mem[r_wr_ptr] <= bus.i_wb_rdt;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_dec_valid   <= 1'b0;
      r_rd_addr     <= '0;
      r_rs1_addr    <= '0;
      r_rs2_addr    <= '0;
      r_mem_op      <= 1'b0;
      r_branch_op   <= 1'b0;
      r_shift_op    <= 1'b0;
      r_slt_op      <= 1'b0;
      r_rd_op       <= 1'b0;
      r_alu_sub     <= 1'b0;
      r_csr_op      <= 1'b0;
      r_e_op        <= 1'b0;
      r_ebreak      <= 1'b0;
      r_funct3      <= '0;
      r_alu_rd_sel  <= '0;
      r_immdec_ctrl <= '0;
      r_imm_raw     <= '0;
    end else if (bus.i_flush) begin
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_dec_valid <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // Bundle holds while presented and not accepted.
      if (w_load) begin
        r_dec_valid   <= 1'b1;
        r_rd_addr     <= w_insn[11:7];
        r_rs1_addr    <= w_insn[19:15];
        r_rs2_addr    <= w_insn[24:20];
        r_mem_op      <= w_mem_op;
        r_branch_op   <= w_branch_op;
        r_shift_op    <= w_shift_op;
        r_slt_op      <= w_slt_op;
        r_rd_op       <= w_rd_op;
        r_alu_sub     <= w_alu_sub;
        r_csr_op      <= w_csr_op;
        r_e_op        <= w_e_op;
        r_ebreak      <= w_insn[20];
        r_funct3      <= w_f3;
        r_alu_rd_sel  <= w_alu_rd_sel;
        r_immdec_ctrl <= w_immdec_ctrl;
        r_imm_raw     <= w_insn[31:7];
      end else if (bus.i_dec_ready) begin
        r_dec_valid <= 1'b0;
      end
    end
  end

`ifdef SERV_DECODE_ILLEGAL_EN
  logic w_opc_known, w_f7_bad, w_illegal;
  logic r_illegal;

  assign w_opc_known = (w_op == OPC_LOAD) || (w_op == OPC_FENCE) || (w_op == OPC_OPIMM) ||
                       (w_op == OPC_AUIPC) || (w_op == OPC_STORE) || (w_op == OPC_OP) ||
                       (w_op == OPC_LUI) || (w_op == OPC_BRANCH) || (w_op == OPC_JALR) ||
                       (w_op == OPC_JAL) || (w_op == OPC_SYSTEM);
  // funct7 0x20 is only meaningful for SUB and SRA.
  assign w_f7_bad = (w_op == OPC_OP) &&
                    !((w_insn[31:25] == 7'h00) ||
                      ((w_insn[31:25] == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
  assign w_illegal = (w_insn[1:0] != 2'b11) || !w_opc_known || w_f7_bad;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_illegal <= 1'b0;
    end else if (!bus.i_flush && w_load) begin
      r_illegal <= w_illegal;
    end
  end

  assign bus.o_illegal = r_illegal;
`else
  logic w_unused_low;
  assign w_unused_low  = &{1'b0, w_insn[1:0]};
  assign bus.o_illegal = 1'b0;
`endif

  assign bus.o_ibuf_full   = (r_count == CNT_FULL);
  assign bus.o_ibuf_count  = r_count;
  assign bus.o_dec_valid   = r_dec_valid;
  assign bus.o_rd_addr     = r_rd_addr;
  assign bus.o_rs1_addr    = r_rs1_addr;
  assign bus.o_rs2_addr    = r_rs2_addr;
  assign bus.o_mem_op      = r_mem_op;
  assign bus.o_branch_op   = r_branch_op;
  assign bus.o_shift_op    = r_shift_op;
  assign bus.o_slt_op      = r_slt_op;
  assign bus.o_rd_op       = r_rd_op;
  assign bus.o_alu_sub     = r_alu_sub;
  assign bus.o_csr_op      = r_csr_op;
  assign bus.o_e_op        = r_e_op;
  assign bus.o_ebreak      = r_ebreak;
  assign bus.o_funct3      = r_funct3;
  assign bus.o_alu_rd_sel  = r_alu_rd_sel;
  assign bus.o_immdec_ctrl = r_immdec_ctrl;
  assign bus.o_imm_raw     = r_imm_raw;
endmodule
`default_nettype wire

// File: tb/tb_serv_decode_q.sv
`default_nettype none
// ============================================================================
// Module   : tb_serv_decode_q
// Purpose  : Vector table plus scoreboard bench for serv_decode_q (DEPTH=2).
// Revision : 1.0
// ============================================================================
module tb_serv_decode_q;
  localparam int DEPTH = 2;
`ifdef SERV_DECODE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  // flags = {mem, branch, shift, slt, rd_op, alu_sub, csr, e_op, ebreak}
  typedef struct packed {
    logic [31:0] insn;
    logic [8:0]  flags;
    logic [3:0]  rdsel;
    logic [3:0]  immc;
    logic        ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serv_decode_q_if #(.DEPTH(DEPTH)) bus ();
  serv_decode_q #(.DEPTH(DEPTH)) u_dut (.clk(clk), .i_rst_n(rst_n), .bus(bus));

  vec_t vt [14];
  vec_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input vec_t v);
    bus.i_wb_rdt = v.insn;
    bus.i_wb_en  = 1'b1;
    sb.push_back(v);
    tick();
    bus.i_wb_en  = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    bus.i_dec_ready = 1'b1;
    while (sb.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    chk(name, sb.size(), 0);
  endtask

  always @(negedge clk) begin : mon
    vec_t e;
    logic [8:0] gf;
    logic ge_ill;
    if (rst_n === 1'b1 && bus.o_dec_valid === 1'b1 && bus.i_dec_ready === 1'b1 &&
        bus.i_flush === 1'b0) begin
      n_cmp++;
      gf = {bus.o_mem_op, bus.o_branch_op, bus.o_shift_op, bus.o_slt_op, bus.o_rd_op,
            bus.o_alu_sub, bus.o_csr_op, bus.o_e_op, bus.o_ebreak};
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_bundle: got rd=%0d flags=%b, required no bundle",
                 bus.o_rd_addr, gf);
      end else begin
        e = sb.pop_front();
        ge_ill = e.ill & ILL_EN;
        if (gf !== e.flags || bus.o_alu_rd_sel !== e.rdsel || bus.o_immdec_ctrl !== e.immc ||
            bus.o_illegal !== ge_ill || bus.o_rd_addr !== e.insn[11:7] ||
            bus.o_rs1_addr !== e.insn[19:15] || bus.o_rs2_addr !== e.insn[24:20] ||
            bus.o_funct3 !== e.insn[14:12] || bus.o_imm_raw !== e.insn[31:7]) begin
          n_bad++;
          $display("FAIL bundle %08h: got flags=%b sel=%b imm=%b ill=%b rd=%0d rs1=%0d rs2=%0d f3=%0d raw=%h, required flags=%b sel=%b imm=%b ill=%b rd=%0d rs1=%0d rs2=%0d f3=%0d raw=%h",
                   e.insn, gf, bus.o_alu_rd_sel, bus.o_immdec_ctrl, bus.o_illegal,
                   bus.o_rd_addr, bus.o_rs1_addr, bus.o_rs2_addr, bus.o_funct3, bus.o_imm_raw,
                   e.flags, e.rdsel, e.immc, ge_ill, e.insn[11:7], e.insn[19:15],
                   e.insn[24:20], e.insn[14:12], e.insn[31:7]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{32'h00500093, 9'b000010001, 4'b0001, 4'b0010, 1'b0}; // addi x1,x0,5
    vt[1]  = '{32'h40208133, 9'b000011000, 4'b0001, 4'b0010, 1'b0}; // sub
    vt[2]  = '{32'h00100073, 9'b000011011, 4'b0001, 4'b1110, 1'b0}; // ebreak
    vt[3]  = '{32'h00000073, 9'b000011010, 4'b0001, 4'b1110, 1'b0}; // ecall
    vt[4]  = '{32'h30200073, 9'b000011000, 4'b0001, 4'b1110, 1'b0}; // mret
    vt[5]  = '{32'h0000000B, 9'b100000000, 4'b0001, 4'b0000, 1'b1}; // custom-0
    vt[6]  = '{32'hFFFFFFFF, 9'b000001001, 4'b1000, 4'b1000, 1'b1};
    vt[7]  = '{32'h00000013, 9'b000010000, 4'b0001, 4'b0010, 1'b0}; // nop
    vt[8]  = '{32'h00219193, 9'b001011000, 4'b0010, 4'b0010, 1'b0}; // slli
    vt[9]  = '{32'h0020A233, 9'b000111000, 4'b0100, 4'b0010, 1'b0}; // slt
    vt[10] = '{32'h0020A423, 9'b100001000, 4'b0100, 4'b0011, 1'b0}; // sw
    vt[11] = '{32'h00208463, 9'b010001000, 4'b0001, 4'b1111, 1'b0}; // beq
    vt[12] = '{32'h02208133, 9'b000010000, 4'b0001, 4'b0010, 1'b1}; // mul
    vt[13] = '{32'h300092F3, 9'b000011100, 4'b0010, 4'b1110, 1'b0}; // csrrw

    rst_n = 1'b0;
    bus.i_wb_rdt = '0;
    bus.i_wb_en = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_dec_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", bus.o_dec_valid, 0);
    chk("rst_count", bus.o_ibuf_count, 0);
    chk("rst_full", bus.o_ibuf_full, 0);
    chk("rst_rd_addr", bus.o_rd_addr, 0);
    chk("rst_alu_rd_sel", bus.o_alu_rd_sel, 0);
    chk("rst_immdec", bus.o_immdec_ctrl, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_valid", bus.o_dec_valid, 0);

    // addi: bypass path gives valid one edge after the push
    bus.i_dec_ready = 1'b1;
    push(vt[0]);
    chk("t1_latency_valid", bus.o_dec_valid, 1);
    tick();
    chk("t1_valid_drop", bus.o_dec_valid, 0);

    for (int i = 0; i < 14; i++) begin
      push(vt[i]);
      chk("stream_count", bus.o_ibuf_count, 0);
    end
    drain("stream_drain");

    // fill decode stage and buffer while stalled, then release in order
    bus.i_dec_ready = 1'b0;
    push(vt[1]);
    push(vt[8]);
    push(vt[9]);
    chk("t2_count", bus.o_ibuf_count, DEPTH);
    chk("t2_full", bus.o_ibuf_full, 1);
    chk("t2_valid", bus.o_dec_valid, 1);
    tick();
    chk("t2_count_hold", bus.o_ibuf_count, DEPTH);
    drain("t2_drain");
    tick();
    chk("t2_count_empty", bus.o_ibuf_count, 0);
    chk("t2_valid_empty", bus.o_dec_valid, 0);

    // push and pop in the same cycle while full
    bus.i_dec_ready = 1'b0;
    push(vt[10]);
    push(vt[11]);
    push(vt[13]);
    bus.i_wb_rdt = vt[2].insn;
    bus.i_wb_en = 1'b1;
    bus.i_dec_ready = 1'b1;
    sb.push_back(vt[2]);
    tick();
    bus.i_wb_en = 1'b0;
    bus.i_dec_ready = 1'b0;
    chk("t3_count", bus.o_ibuf_count, DEPTH);
    chk("t3_full", bus.o_ibuf_full, 1);
    drain("t3_drain");

    // flush with a same-cycle push: everything queued is discarded
    bus.i_dec_ready = 1'b0;
    push(vt[0]);
    push(vt[1]);
    push(vt[8]);
    bus.i_flush = 1'b1;
    bus.i_wb_rdt = vt[3].insn;
    bus.i_wb_en = 1'b1;
    sb.delete();
    tick();
    bus.i_flush = 1'b0;
    bus.i_wb_en = 1'b0;
    chk("t4_count", bus.o_ibuf_count, 0);
    chk("t4_valid", bus.o_dec_valid, 0);
    chk("t4_full", bus.o_ibuf_full, 0);
    tick();
    chk("t4_valid_idle", bus.o_dec_valid, 0);
    bus.i_dec_ready = 1'b1;
    push(vt[1]);
    chk("t4_latency_valid", bus.o_dec_valid, 1);
    drain("t4_drain");

    // system instructions and illegal candidates through the buffer
    bus.i_dec_ready = 1'b0;
    push(vt[2]);
    push(vt[3]);
    push(vt[4]);
    drain("t5_drain");
    bus.i_dec_ready = 1'b0;
    push(vt[5]);
    push(vt[6]);
    push(vt[7]);
    drain("t6_drain");

    // asynchronous reset in mid-cycle
    bus.i_dec_ready = 1'b0;
    push(vt[0]);
    push(vt[9]);
    chk("t6_pre_count", bus.o_ibuf_count, 1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("t6_async_valid", bus.o_dec_valid, 0);
    chk("t6_async_count", bus.o_ibuf_count, 0);
    chk("t6_async_rd", bus.o_rd_addr, 0);
    chk("t6_async_ebreak", bus.o_ebreak, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_valid", bus.o_dec_valid, 0);
    bus.i_dec_ready = 1'b1;
    push(vt[12]);
    chk("t6_post_latency", bus.o_dec_valid, 1);
    drain("t6_post_drain");
    tick();
    chk("final_valid", bus.o_dec_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
